// File: rtl/cycle_monitor_if.sv
// Handshake/result bundle for cycle_monitor.
//   master : drives start and sig_in, observes the verdict outputs
//   slave  : the monitor itself
//   start  - single-cycle arm pulse
//   sig_in - observed level
//   busy, done, ok, early, late, drop - status and verdict flags
//   meas   - measured cycle count of the last verdict (CW bits)
interface cycle_monitor_if #(
  parameter int CW = 6
) ();
  logic          start;
  logic          sig_in;
  logic          busy;
  logic          done;
  logic          ok;
  logic          early;
  logic          late;
  logic          drop;
  logic [CW-1:0] meas;

  modport master (
    output start, sig_in,
    input  busy, done, ok, early, late, drop, meas
  );

  modport slave (
    input  start, sig_in,
    output busy, done, ok, early, late, drop, meas
  );
endinterface

// File: rtl/cycle_monitor.sv
// cycle_monitor: measures the number of cycles from a start pulse to the
// first high sample of sig_in and classifies it against a window of
// EXP_CYCLES +/- TOL, with a TIMEOUT for a rise that never comes. After a
// good rise the level is watched and a fall is reported as drop.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - cycle_monitor_if.slave (start, sig_in in; busy, done, ok,
//         early, late, drop, meas out)
// Build option: define CYCLE_MONITOR_SYNC_EN to pass sig_in through a
// 2-flop synchronizer; the measured count is corrected for the two extra
// cycles so meas matches the direct-sampling build.
module cycle_monitor #(
  parameter int EXP_CYCLES = 37,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 63,
  parameter int CW         = 6
) (
  input  logic             clk,
  input  logic             rst,
  cycle_monitor_if.slave   bus
);

  // One spare bit so the window bounds and the synchronizer-corrected
  // count never wrap.
  typedef logic [CW:0] cnt_t;

  typedef enum logic [1:0] {IDLE, COUNT, HOLD, FAIL} state_t;

  localparam cnt_t LO_W = (EXP_CYCLES > TOL) ? cnt_t'(EXP_CYCLES - TOL) : cnt_t'(0);
  localparam cnt_t HI_W = cnt_t'(EXP_CYCLES + TOL);
  localparam cnt_t TO_W = cnt_t'(TIMEOUT);

  logic samp_s;

`ifdef CYCLE_MONITOR_SYNC_EN
  localparam cnt_t LAT_W = cnt_t'(2);
  logic [1:0] sync_r;

  // Two-flop synchronizer for the observed level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], bus.sig_in};
    end
  end
  assign samp_s = sync_r[1];
`else
  localparam cnt_t LAT_W = cnt_t'(0);
  assign samp_s = bus.sig_in;
`endif

  state_t        state_r, state_s;
  cnt_t          cnt_r, cnt_s;
  cnt_t          adj_s;
  logic [CW-1:0] meas_r, meas_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          ok_r, ok_s;
  logic          early_r, early_s;
  logic          late_r, late_s;
  logic          drop_r, drop_s;

  // Count as seen at the input pin, with synchronizer latency removed.
  assign adj_s = cnt_r - LAT_W;

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= cnt_t'(0);
      meas_r  <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ok_r    <= 1'b0;
      early_r <= 1'b0;
      late_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      meas_r  <= meas_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ok_r    <= ok_s;
      early_r <= early_s;
      late_r  <= late_s;
      drop_r  <= drop_s;
    end
  end

  // Next-state, counter and verdict logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    meas_s  = meas_r;
    done_s  = 1'b0;
    ok_s    = ok_r;
    early_s = early_r;
    late_s  = late_r;
    drop_s  = drop_r;

    // start re-arms from every state, and beats a same-cycle rise sample.
    if (bus.start) begin
      state_s = COUNT;
      cnt_s   = cnt_t'(1);
      meas_s  = {CW{1'b0}};
      ok_s    = 1'b0;
      early_s = 1'b0;
      late_s  = 1'b0;
      drop_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        COUNT: begin
          // Samples still carrying pre-start synchronizer contents are skipped.
          if ((cnt_r > LAT_W) && samp_s) begin
            meas_s = adj_s[CW-1:0];
            done_s = 1'b1;
            if (adj_s < LO_W) begin
              early_s = 1'b1;
              state_s = FAIL;
            end else if (adj_s > HI_W) begin
              late_s  = 1'b1;
              state_s = FAIL;
            end else begin
              ok_s    = 1'b1;
              state_s = HOLD;
            end
          end else if (adj_s == TO_W) begin
            meas_s  = TO_W[CW-1:0];
            done_s  = 1'b1;
            late_s  = 1'b1;
            state_s = FAIL;
          end else begin
            cnt_s = cnt_r + cnt_t'(1);
          end
        end
        HOLD: begin
          if (!samp_s) begin
            ok_s    = 1'b0;
            drop_s  = 1'b1;
            state_s = FAIL;
          end else begin
            state_s = HOLD;
          end
        end
        FAIL: begin
          state_s = FAIL;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = cnt_t'(0);
        end
      endcase
    end

    busy_s = (state_s == COUNT);
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.ok    = ok_r;
  assign bus.early = early_r;
  assign bus.late  = late_r;
  assign bus.drop  = drop_r;
  assign bus.meas  = meas_r;

endmodule

// File: tb/tb_cycle_monitor.sv
// Self-checking bench for cycle_monitor with default parameters: a table of
// hand-derived vectors, hand-written reset/restart sequences, and random
// scenarios checked against a rule-level reference model.
module tb_cycle_monitor;

  localparam int EXP_CYCLES = 37;
  localparam int TOL        = 1;
  localparam int TIMEOUT    = 63;
  localparam int CW         = 6;
  localparam int WIN        = 80;
`ifdef CYCLE_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cycle_monitor_if #(.CW(CW)) bus ();

  cycle_monitor #(
    .EXP_CYCLES(EXP_CYCLES), .TOL(TOL), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       rise;     // cycle index of first high level, 0 = never
    int       hold;     // cycles high before falling, -1 = stays high
    logic [3:0] flags;  // {ok, early, late, drop}
    int       meas;
    int       vcyc;     // counter value at which the verdict is taken
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int flags_now();
    return {28'd0, bus.ok, bus.early, bus.late, bus.drop};
  endfunction

  // Reference model from the window rules.
  function automatic vec_t model(input int rise, input int hold);
    vec_t v;
    int lo;
    lo = (EXP_CYCLES > TOL) ? EXP_CYCLES - TOL : 0;
    v.rise = rise;
    v.hold = hold;
    if (rise == 0 || rise > TIMEOUT) begin
      v.flags = 4'b0010; v.meas = TIMEOUT; v.vcyc = TIMEOUT;
    end else begin
      v.meas = rise; v.vcyc = rise;
      if (rise < lo)                     v.flags = 4'b0100;
      else if (rise > EXP_CYCLES + TOL)  v.flags = 4'b0010;
      else if (hold >= 0)                v.flags = 4'b0001;
      else                               v.flags = 4'b1000;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse; returns in COUNT cycle 1.
  task automatic arm();
    bus.start  = 1'b1;
    bus.sig_in = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic measure(input int rise, input int hold,
                         output int done_cyc, output int done_cnt);
    done_cyc = -1;
    done_cnt = 0;
    for (int k = 1; k <= WIN; k++) begin
      bus.sig_in = (rise > 0 && k >= rise && (hold < 0 || k < rise + hold));
      tick();
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int dc, dn;
    arm();
    measure(v.rise, v.hold, dc, dn);
    check({tag, " done_cycle"}, dc, v.vcyc + LAT);
    check({tag, " done_count"}, dn, 1);
    check({tag, " flags"}, flags_now(), int'(v.flags));
    check({tag, " meas"}, int'(bus.meas), v.meas);
    check({tag, " busy"}, int'(bus.busy), 0);
  endtask

  vec_t tbl[10];

  initial begin
    int dc, dn;
    bus.start  = 1'b0;
    bus.sig_in = 1'b0;

    tbl[0] = '{37, -1, 4'b1000, 37, 37};
    tbl[1] = '{36, -1, 4'b1000, 36, 36};
    tbl[2] = '{38, -1, 4'b1000, 38, 38};
    tbl[3] = '{35, -1, 4'b0100, 35, 35};
    tbl[4] = '{39, -1, 4'b0010, 39, 39};
    tbl[5] = '{ 0, -1, 4'b0010, 63, 63};
    tbl[6] = '{ 1, -1, 4'b0100,  1,  1};
    tbl[7] = '{63, -1, 4'b0010, 63, 63};
    tbl[8] = '{64, -1, 4'b0010, 63, 63};
    tbl[9] = '{37,  5, 4'b0001, 37, 37};

    // Reset state, and no activity without start.
    #12;
    check("reset flags", flags_now(), 0);
    check("reset busy_done", int'({bus.busy, bus.done}), 0);
    check("reset meas", int'(bus.meas), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dn += int'(bus.busy) + int'(bus.done);
    end
    check("idle stays idle", dn, 0);

    // First COUNT cycle shows busy.
    arm();
    check("count busy", int'(bus.busy), 1);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Re-arm after drop clears everything.
    arm();
    check("rearm flags", flags_now(), 0);
    check("rearm meas", int'(bus.meas), 0);
    check("rearm busy", int'(bus.busy), 1);

    // Async reset in COUNT cycle 20.
    for (int k = 1; k < 20; k++) tick();
    #3;
    rst = 1'b1;
    #1;
    check("rst flags", flags_now(), 0);
    check("rst busy_done_meas", int'({bus.busy, bus.done, bus.meas}), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      dn += int'(bus.busy) + int'(bus.done);
    end
    check("rst no done no busy", dn, 0);
    run_vec("after rst", model(37, -1));

    // Restart at COUNT cycle 10, colliding with a high sample.
    arm();
    for (int k = 1; k < 10; k++) tick();
    bus.start  = 1'b1;
    bus.sig_in = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart no done", int'(bus.done), 0);
    check("restart flags", flags_now(), 0);
    measure(37, -1, dc, dn);
    check("restart done_cycle", dc, 37 + LAT);
    check("restart done_count", dn, 1);
    check("restart flags final", flags_now(), 8);
    check("restart meas", int'(bus.meas), 37);

    // Random scenarios against the reference model.
    for (int i = 0; i < 40; i++) begin
      int r, h;
      r = $urandom_range(0, 70);
      h = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 8);
      run_vec($sformatf("rnd%0d r=%0d h=%0d", i, r, h), model(r, h));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_monitor.md
CYCLE_MONITOR -- requirements
Module: cycle_monitor

Interface
REQ-001 Parameter EXP_CYCLES, default 37, expected cycles from start to first high sample of sig_in.
REQ-002 Parameter TOL, default 1, allowed +/- deviation from EXP_CYCLES.
REQ-003 Parameter TIMEOUT, default 63, cycle count at which a missing rise is declared late.
REQ-004 Parameter CW, default 6, width of the cycle counter and meas.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse that arms a measurement.
REQ-008 sig_in  in  1  observed signal; a level that rises once and then stays high.
REQ-009 busy  out  1  high while a measurement is in progress.
REQ-010 done  out  1  one-cycle pulse when a verdict is issued.
REQ-011 ok  out  1  rise was inside the window and the level is still held.
REQ-012 early  out  1  rise came before EXP_CYCLES-TOL.
REQ-013 late  out  1  rise came after EXP_CYCLES+TOL, or never came before TIMEOUT.
REQ-014 drop  out  1  sig_in fell after a correct rise.
REQ-015 meas  out  CW  measured cycle count of the last verdict.

Function
REQ-016 The FSM SHALL have four states: IDLE, COUNT, HOLD and FAIL.
REQ-017 IDLE: busy=0; start=1 moves to COUNT, clears counter, meas and all flags.
REQ-018 COUNT: busy=1; counter increments by 1 each cycle; the first COUNT cycle holds counter value 1.
REQ-019 sig_in is not sampled in the start cycle itself.
REQ-020 First sample of sig_in=1 in COUNT at counter value N: meas<=N, done=1 on the next edge (1-cycle latency), then classify.
REQ-021 Classification: EXP_CYCLES-TOL <= N <= EXP_CYCLES+TOL sets ok=1 and goes to HOLD.
REQ-022 Classification: N < EXP_CYCLES-TOL sets early=1 and goes to FAIL.
REQ-023 Classification: N > EXP_CYCLES+TOL sets late=1 and goes to FAIL.
REQ-024 Counter reaching TIMEOUT with no high sample: late=1, meas=TIMEOUT, done=1, go to FAIL.
REQ-025 Comparisons SHALL be unsigned on CW+1 bits; EXP_CYCLES-TOL below 0 SHALL clamp to 0 (early never asserts).
REQ-026 HOLD: busy=0; ok stays 1 while sig_in=1.
REQ-027 HOLD, sig_in sampled 0: ok<=0, drop<=1, go to FAIL; no second done pulse.
REQ-028 FAIL: all flags and meas SHALL hold until start or rst.
REQ-029 start in HOLD or FAIL SHALL re-arm exactly as from IDLE.
REQ-030 start in COUNT SHALL restart the measurement: counter to 0, no done pulse, flags stay clear.
REQ-031 start and the rise sample in the same COUNT cycle: start wins, and the sample is discarded.
REQ-032 At most one of ok/early/late SHALL be high at any time; drop excludes ok.
REQ-033 Legal parameters: EXP_CYCLES+TOL < TIMEOUT <= 2^CW-1; other values are unsupported.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, counter=0, meas=0, and busy, done, ok, early, late and drop all 0, regardless of clk.
REQ-035 rst asserted mid-COUNT SHALL abandon the measurement without a done pulse.
REQ-036 After rst deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-037 Macro CYCLE_MONITOR_SYNC_EN defined: sig_in SHALL pass through a 2-flop synchronizer.
REQ-038 With CYCLE_MONITOR_SYNC_EN, the sampled count SHALL be reduced by 2 before storing and classifying, so meas matches the unsynchronized build for the same waveform.
REQ-039 Macro CYCLE_MONITOR_SYNC_EN undefined: sig_in SHALL be sampled directly, with no added latency.

Verification
REQ-040 Defaults, start, sig_in rises in COUNT cycle 37 -> next cycle done=1, ok=1, meas=37, busy=0.
REQ-041 sig_in rises at cycle 36 -> ok=1, meas=36; rises at cycle 35 -> early=1, meas=35, ok=0.
REQ-042 sig_in rises at cycle 39 -> late=1, meas=39; sig_in never rises -> late=1, meas=63 one cycle after counter hits 63.
REQ-043 ok at cycle 37, then sig_in low 5 cycles later -> drop=1, ok=0, no done pulse; start then re-arms with all flags 0.
REQ-044 rst pulsed at COUNT cycle 20 -> all outputs 0 immediately, IDLE, no done; a later start measures normally.
REQ-045 start re-pulsed at COUNT cycle 10 and rise 37 cycles after the second start -> ok=1, meas=37; repeat with CYCLE_MONITOR_SYNC_EN defined -> identical meas.
